dmac_wr_burst_ctrl: RTL and testbench



---
 rtl/dmac_wr_burst_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dmac_wr_burst_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_wr_burst_ctrl.sv
// Write-side burst engine: splits a write command into 4 KB-safe AXI4 INCR bursts,
// claims the buffered beats of each burst, then streams W and collects B, one burst at a time.
module dmac_wr_burst_ctrl #(
   parameter int  ADDR_WD       = 32,
   parameter int  DATA_WD       = 32,
   parameter int  MAX_BURST_LEN = 16,
   localparam int UW            = $clog2(MAX_BURST_LEN) + 2
) (
   input  logic                 clk,
   input  logic                 rst,
   // command
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [ADDR_WD-1:0]   cmd_addr,
   input  logic [15:0]          cmd_beats,
   // buffer usage / claim
   input  logic [UW-1:0]        buf_usage,
   output logic                 dec_usage_valid,
   output logic [UW-1:0]        dec_usage_count,
   // buffer read port
   input  logic                 buf_valid,
   output logic                 buf_ready,
   input  logic [DATA_WD-1:0]   buf_data,
   // AXI AW
   output logic                 awvalid,
   input  logic                 awready,
   output logic [ADDR_WD-1:0]   awaddr,
   output logic [7:0]           awlen,
   output logic [2:0]           awsize,
   output logic [1:0]           awburst,
   // AXI W
   output logic                 wvalid,
   input  logic                 wready,
   output logic [DATA_WD-1:0]   wdata,
   output logic [DATA_WD/8-1:0] wstrb,
   output logic                 wlast,
   // AXI B
   input  logic                 bvalid,
   output logic                 bready,
   input  logic [1:0]           bresp,
   // status
   output logic                 done,
   output logic                 err
);

   localparam int BYTES   = DATA_WD / 8;
   localparam int SIZE_LG = $clog2(BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_WAIT,
      S_AW,
      S_W,
      S_B,
      S_FIN
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [ADDR_WD-1:0]  addr_q;
   logic [15:0]         rem_q;
   logic [UW-1:0]       blen_q;
   logic [UW-1:0]       beat_q;
   logic                err_q;

   logic [12:0]         room_bytes;
   logic [12:0]         room_beats;
   logic [16:0]         blen_lim;
   logic [UW-1:0]       blen_calc;
   logic                usage_ok;
   logic                last_beat;
   logic                w_hs;
   logic                b_last;

   // Burst length: limited by the remaining beats, the burst cap and the distance to the next 4 KB page.
   assign room_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
   assign room_beats = room_bytes >> SIZE_LG;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      blen_lim = 17'(MAX_BURST_LEN);
      if (17'(room_beats) < blen_lim) blen_lim = 17'(room_beats);
      if (17'(rem_q) < blen_lim)      blen_lim = 17'(rem_q);
      blen_calc = UW'(blen_lim);
   end

   assign usage_ok  = (buf_usage >= blen_q);
   assign last_beat = (beat_q == blen_q - UW'(1));
   assign w_hs      = wvalid && wready;
   assign b_last    = (rem_q == 16'(blen_q));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (cmd_valid) state_nxt = S_CALC;
         // A zero-beat command passes through CALC so done lands two cycles after accept.
         S_CALC: state_nxt = (rem_q == 16'd0) ? S_FIN : S_WAIT;
         S_WAIT: if (usage_ok) state_nxt = S_AW;
         S_AW:   if (awready) state_nxt = S_W;
         S_W:    if (w_hs && last_beat) state_nxt = S_B;
         S_B:    if (bvalid) state_nxt = b_last ? S_FIN : S_CALC;
         S_FIN:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Address, remaining count, burst length and beat counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
         rem_q  <= '0;
         blen_q <= '0;
         beat_q <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  addr_q <= cmd_addr;
                  rem_q  <= cmd_beats;
                  err_q  <= 1'b0;
               end
            end
            S_CALC: begin
               blen_q <= blen_calc;
               beat_q <= '0;
            end
            S_W: begin
               if (w_hs) beat_q <= beat_q + UW'(1);
            end
            S_B: begin
               if (bvalid) begin
                  if (bresp[1]) err_q <= 1'b1;
                  addr_q <= addr_q + (ADDR_WD'(blen_q) << SIZE_LG);
                  rem_q  <= rem_q - 16'(blen_q);
               end
            end
            default: ;
         endcase
      end
   end

   // Output logic
   always_comb begin
      cmd_ready       = 1'b0;
      dec_usage_valid = 1'b0;
      dec_usage_count = '0;
      awvalid         = 1'b0;
      wvalid          = 1'b0;
      buf_ready       = 1'b0;
      bready          = 1'b0;
      done            = 1'b0;
      case (state)
         S_IDLE: cmd_ready = 1'b1;
         S_WAIT: begin
            if (usage_ok) begin
               dec_usage_valid = 1'b1;
               dec_usage_count = blen_q;
            end
         end
         S_AW:   awvalid = 1'b1;
         S_W: begin
            wvalid    = buf_valid;
            buf_ready = wready;
         end
         S_B:    bready = 1'b1;
         S_FIN:  done = 1'b1;
         default: ;
      endcase
   end

   assign awaddr  = addr_q;
   assign awlen   = 8'(blen_q - UW'(1));
   assign awsize  = 3'(SIZE_LG);
   assign awburst = 2'b01;
   assign wdata   = buf_data;
   assign wstrb   = '1;
   assign wlast   = (state == S_W) && last_beat;
   assign err     = err_q;

endmodule

// File: tb/tb_dmac_wr_burst_ctrl.sv
// Self-checking bench for dmac_wr_burst_ctrl: table of commands with hand-computed burst splits,
// plus directed sequences for latency, starvation, zero-beat, backpressure/error and reset.
module tb_dmac_wr_burst_ctrl;

   localparam int ADDR_WD       = 32;
   localparam int DATA_WD       = 32;
   localparam int MAX_BURST_LEN = 16;
   localparam int UW            = $clog2(MAX_BURST_LEN) + 2;

   logic                 clk;
   logic                 rst;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [ADDR_WD-1:0]   cmd_addr;
   logic [15:0]          cmd_beats;
   logic [UW-1:0]        buf_usage;
   logic                 dec_usage_valid;
   logic [UW-1:0]        dec_usage_count;
   logic                 buf_valid;
   logic                 buf_ready;
   logic [DATA_WD-1:0]   buf_data;
   logic                 awvalid;
   logic                 awready;
   logic [ADDR_WD-1:0]   awaddr;
   logic [7:0]           awlen;
   logic [2:0]           awsize;
   logic [1:0]           awburst;
   logic                 wvalid;
   logic                 wready;
   logic [DATA_WD-1:0]   wdata;
   logic [DATA_WD/8-1:0] wstrb;
   logic                 wlast;
   logic                 bvalid;
   logic                 bready;
   logic [1:0]           bresp;
   logic                 done;
   logic                 err;

   dmac_wr_burst_ctrl #(
      .ADDR_WD      (ADDR_WD),
      .DATA_WD      (DATA_WD),
      .MAX_BURST_LEN(MAX_BURST_LEN)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_addr       (cmd_addr),
      .cmd_beats      (cmd_beats),
      .buf_usage      (buf_usage),
      .dec_usage_valid(dec_usage_valid),
      .dec_usage_count(dec_usage_count),
      .buf_valid      (buf_valid),
      .buf_ready      (buf_ready),
      .buf_data       (buf_data),
      .awvalid        (awvalid),
      .awready        (awready),
      .awaddr         (awaddr),
      .awlen          (awlen),
      .awsize         (awsize),
      .awburst        (awburst),
      .wvalid         (wvalid),
      .wready         (wready),
      .wdata          (wdata),
      .wstrb          (wstrb),
      .wlast          (wlast),
      .bvalid         (bvalid),
      .bready         (bready),
      .bresp          (bresp),
      .done           (done),
      .err            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- monitor ----------------
   logic [31:0] aw_addr_q[$];
   int          aw_len_q[$];
   int          dec_q[$];
   logic [31:0] w_data_q[$];
   bit          w_last_q[$];
   int          done_n, aw_bad_attr, aw_unstable, dec_bad, w_early, w_bad_strb;
   bit          aw_stall_prev, dec_prev, aw_open;
   logic [31:0] aw_addr_prev;
   logic [7:0]  aw_len_prev;

   always @(negedge clk) begin
      if (!rst) begin
         aw_stall_prev = 0;
         dec_prev      = 0;
         aw_open       = 0;
      end else begin
         if (dec_usage_valid) dec_q.push_back(int'(dec_usage_count));
         if (dec_usage_valid && dec_prev) dec_bad++;
         if (!dec_usage_valid && dec_usage_count != '0) dec_bad++;
         dec_prev = dec_usage_valid;
         if (aw_stall_prev && (!awvalid || awaddr != aw_addr_prev || awlen != aw_len_prev)) aw_unstable++;
         aw_stall_prev = awvalid && !awready;
         aw_addr_prev  = awaddr;
         aw_len_prev   = awlen;
         if (wvalid && !aw_open) w_early++;
         if (awvalid && awready) begin
            aw_addr_q.push_back(awaddr);
            aw_len_q.push_back(int'(awlen));
            if (awsize != 3'd2 || awburst != 2'b01) aw_bad_attr++;
            aw_open = 1;
         end
         if (wvalid && wready) begin
            w_data_q.push_back(wdata);
            w_last_q.push_back(wlast);
            if (wstrb != 4'hF) w_bad_strb++;
            if (wlast) aw_open = 0;
         end
         if (done) done_n++;
      end
   end

   // ---------------- AXI slave + buffer model ----------------
   bit stall_mode;
   int bad_b_idx;
   int b_idx;
   int b_pending;
   int ptr;

   initial begin : axi_slave
      bit hs_buf, hs_wlast, hs_b;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; buf_valid = 0; buf_data = 0;
      b_pending = 0; b_idx = 0; ptr = 0;
      forever begin
         @(negedge clk);
         hs_buf   = buf_valid && buf_ready;
         hs_wlast = wvalid && wready && wlast;
         hs_b     = bvalid && bready;
         @(posedge clk);
         #1;
         if (!rst) begin
            b_pending = 0; bvalid = 0; awready = 0; wready = 0; buf_valid = 0;
         end else begin
            if (hs_buf) ptr++;
            if (hs_wlast) b_pending++;
            if (hs_b) begin
               b_pending--;
               b_idx++;
               bvalid = 0;
            end
            awready = stall_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
            wready  = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (!(buf_valid && !hs_buf)) buf_valid = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (!bvalid && b_pending > 0 && (!stall_mode || $urandom_range(0, 3) == 0)) begin
               bvalid = 1;
               bresp  = (b_idx == bad_b_idx) ? 2'b10 : 2'b00;
            end
         end
         buf_data = 32'hA500_0000 + ptr;
      end
   end

   // ---------------- vectors ----------------
   typedef struct {
      logic [31:0] addr;
      logic [15:0] beats;
      int          nb;
      logic [31:0] baddr [3];
      int          blen  [3];
   } vec_t;

   function automatic vec_t mk(input logic [31:0] addr, input logic [15:0] beats, input int nb,
                               input logic [31:0] a0, input int l0, input logic [31:0] a1, input int l1,
                               input logic [31:0] a2, input int l2);
      vec_t v;
      v.addr = addr; v.beats = beats; v.nb = nb;
      v.baddr[0] = a0; v.blen[0] = l0;
      v.baddr[1] = a1; v.blen[1] = l1;
      v.baddr[2] = a2; v.blen[2] = l2;
      return v;
   endfunction

   task automatic clear_mon();
      aw_addr_q.delete(); aw_len_q.delete(); dec_q.delete(); w_data_q.delete(); w_last_q.delete();
      done_n = 0;
      b_idx  = 0;
   endtask

   task automatic issue_cmd(input logic [31:0] addr, input logic [15:0] beats);
      bit seen = 0;
      @(posedge clk);
      #1;
      cmd_valid = 1; cmd_addr = addr; cmd_beats = beats;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            seen = 1;
            break;
         end
      end
      if (!seen) check("cmd_ready timeout", {31'd0, seen}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      check($sformatf("%s done seen", tag), {31'd0, seen}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int bad_idx, input bit stall, input bit exp_err, input string tag);
      int base, sum, idx, bad;
      clear_mon();
      stall_mode = stall;
      bad_b_idx  = bad_idx;
      base       = ptr;
      issue_cmd(v.addr, v.beats);
      wait_done(tag, 3000);
      repeat (2) @(negedge clk);
      stall_mode = 0;
      check($sformatf("%s n_aw", tag), aw_addr_q.size(), v.nb);
      check($sformatf("%s n_dec", tag), dec_q.size(), v.nb);
      sum = 0;
      for (int b = 0; b < v.nb; b++) begin
         sum += v.blen[b];
         check($sformatf("%s dec[%0d]", tag, b), (b < dec_q.size()) ? dec_q[b] : -1, v.blen[b]);
         check($sformatf("%s awaddr[%0d]", tag, b), (b < aw_addr_q.size()) ? aw_addr_q[b] : 32'hDEAD_BEEF, v.baddr[b]);
         check($sformatf("%s awlen[%0d]", tag, b), (b < aw_len_q.size()) ? aw_len_q[b] : -1, v.blen[b] - 1);
      end
      check($sformatf("%s w beats", tag), w_data_q.size(), sum);
      bad = 0;
      for (int i = 0; i < w_data_q.size(); i++)
         if (w_data_q[i] != 32'hA500_0000 + 32'(base + i)) bad++;
      check($sformatf("%s wdata errors", tag), bad, 0);
      idx = 0; bad = 0;
      for (int i = 0; i < w_last_q.size(); i++) if (w_last_q[i]) bad++;
      check($sformatf("%s wlast count", tag), bad, v.nb);
      for (int b = 0; b < v.nb; b++) begin
         idx += v.blen[b];
         check($sformatf("%s wlast pos[%0d]", tag, b), (idx - 1 < w_last_q.size()) ? w_last_q[idx-1] : 1'b0, 1);
      end
      check($sformatf("%s done count", tag), done_n, 1);
      check($sformatf("%s err", tag), err, exp_err);
      check($sformatf("%s cmd_ready", tag), cmd_ready, 1);
   endtask

   task automatic zero_cmd(input string tag);
      clear_mon();
      issue_cmd(32'h40, 16'd0);
      @(negedge clk);
      check($sformatf("%s done@1", tag), done, 0);
      @(negedge clk);
      check($sformatf("%s done@2", tag), done, 1);
      @(negedge clk);
      check($sformatf("%s done@3", tag), done, 0);
      check($sformatf("%s cmd_ready", tag), cmd_ready, 1);
      check($sformatf("%s no aw/w/dec", tag), aw_addr_q.size() + w_data_q.size() + dec_q.size(), 0);
   endtask

   vec_t vecs [7];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      int bad;
      vecs[0] = mk(32'h0000_1000, 16, 1, 32'h1000, 16, 0, 0, 0, 0);
      vecs[1] = mk(32'h0000_0000, 40, 3, 32'h0000, 16, 32'h0040, 16, 32'h0080, 8);
      vecs[2] = mk(32'h0000_0FF8,  6, 2, 32'h0FF8,  2, 32'h1000,  4, 0, 0);
      vecs[3] = mk(32'h0000_0FC0, 20, 2, 32'h0FC0, 16, 32'h1000,  4, 0, 0);
      vecs[4] = mk(32'h0000_1FFC,  3, 2, 32'h1FFC,  1, 32'h2000,  2, 0, 0);
      vecs[5] = mk(32'hFFFF_FFF8,  4, 2, 32'hFFFF_FFF8, 2, 32'h0000_0000, 2, 0, 0);
      vecs[6] = mk(32'h0000_02F0, 17, 2, 32'h02F0, 16, 32'h0330,  1, 0, 0);

      rst = 0; cmd_valid = 0; cmd_addr = 0; cmd_beats = 0; buf_usage = 0;
      stall_mode = 0; bad_b_idx = -1;
      done_n = 0; aw_bad_attr = 0; aw_unstable = 0; dec_bad = 0; w_early = 0; w_bad_strb = 0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("in-reset outputs", {awvalid, wvalid, bready, dec_usage_valid, done, buf_ready, err}, 0);
      #1 rst = 1;
      @(negedge clk);
      check("reset cmd_ready", cmd_ready, 1);
      check("reset outputs", {awvalid, wvalid, bready, dec_usage_valid, done, buf_ready, err}, 0);

      // table-driven commands
      buf_usage = 6'd32;
      for (int i = 0; i < 7; i++) run_vec(vecs[i], -1, 0, 0, $sformatf("vec%0d", i));

      // accept -> dec in 2 cycles, awvalid the cycle after
      clear_mon();
      issue_cmd(32'h300, 16'd1);
      @(negedge clk);
      check("lat dec@1", dec_usage_valid, 0);
      @(negedge clk);
      check("lat dec@2", dec_usage_valid, 1);
      check("lat dec count", dec_usage_count, 1);
      @(negedge clk);
      check("lat awvalid", awvalid, 1);
      check("lat dec off", dec_usage_valid, 0);
      wait_done("lat", 200);

      // starved buffer
      clear_mon();
      buf_usage = 6'd5;
      issue_cmd(32'h0, 16'd16);
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (dec_usage_valid || awvalid) bad++;
      end
      check("starve no dec/aw", bad, 0);
      @(posedge clk);
      #1 buf_usage = 6'd16;
      @(negedge clk);
      check("starve dec", dec_usage_valid, 1);
      check("starve dec count", dec_usage_count, 16);
      check("starve no aw yet", awvalid, 0);
      @(negedge clk);
      check("starve awvalid", awvalid, 1);
      wait_done("starve", 200);
      check("starve w beats", w_data_q.size(), 16);
      buf_usage = 6'd32;

      // zero-beat command
      zero_cmd("zero");

      // backpressure with SLVERR on the second burst
      run_vec(vecs[1], 1, 1, 1, "stall_err");
      run_vec(vecs[3], -1, 1, 0, "stall_4k");
      run_vec(vecs[1], 1, 1, 1, "stall_err2");
      issue_cmd(32'h80, 16'd0);
      check("err cleared on accept", err, 0);
      wait_done("err_clr", 50);

      // reset mid-burst
      clear_mon();
      issue_cmd(32'h0, 16'd16);
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (w_data_q.size() >= 7) begin
            bad = 1;
            break;
         end
      end
      check("reached beat 7", bad, 1);
      rst = 0;
      #1;
      check("rst outputs now", {awvalid, wvalid, bready, dec_usage_valid, done, buf_ready}, 0);
      @(negedge clk);
      check("rst outputs held", {awvalid, wvalid, bready, dec_usage_valid, done, buf_ready, err}, 0);
      #1 rst = 1;
      @(negedge clk);
      check("post-rst cmd_ready", cmd_ready, 1);
      run_vec(mk(32'h500, 5, 1, 32'h500, 5, 0, 0, 0, 0), -1, 0, 0, "post_rst");
      zero_cmd("post_rst_zero");

      // protocol watchers accumulated over the whole run
      check("aw attr errors", aw_bad_attr, 0);
      check("aw unstable while stalled", aw_unstable, 0);
      check("dec pulse errors", dec_bad, 0);
      check("w before aw", w_early, 0);
      check("wstrb errors", w_bad_strb, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
